// File: rtl/z80_uart_pkg.sv
// Shared definitions for the Z80 UART receive path: status register layout,
// bus-cycle state encoding and the count saturation helper.
package z80_uart_pkg;

    // Status byte layout: bit7 = sticky overrun, bits4:0 = saturated fill count
    localparam int STAT_OVR     = 7;
    localparam int STAT_CNT_MSB = 4;

    // Bus cycle tracker: idle, or inside a CPU read waiting for its end
    typedef enum logic {
        RXB_IDLE,
        RXB_RD
    } rxbus_state_t;

    // Clamp a fill count to the 5-bit status field
    function automatic logic [4:0] sat_count5(input int unsigned c);
        logic [31:0] cv;
        cv = c;
        return (cv > 32'd31) ? 5'd31 : cv[4:0];
    endfunction

endpackage

// File: rtl/z80_uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count. Push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise the write is
// reported on 'drop'. Written generically so the TX buffer can reuse it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Decide which operations actually happen and compute next pointers/count
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata      = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;
    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign drop       = push && !do_push;

endmodule

// File: rtl/z80_uart_rx_fifo.sv
// z80_uart_rx_fifo: receive buffer between the UART byte receiver and the Z80
// bus. Data register at addr0=0, status register at addr0=1. A data read of an
// empty FIFO holds mwait low until a byte arrives.
// Optional feature macro: Z80_UART_RXFIFO_IRQ_EN adds the registered irq_n
// output that asserts while the fill level is at or above IRQ_LEVEL.
module z80_uart_rx_fifo
    import z80_uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int IRQ_LEVEL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rdn,
    input  logic       addr0,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] dslave,
    output logic       mwait,
    output logic       full,
    output logic       empty
`ifdef Z80_UART_RXFIFO_IRQ_EN
    ,
    output logic       irq_n
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    rxbus_state_t state_q, state_d;
    logic         sel_q, sel_d;
    logic         overrun_q, overrun_d;
    logic         bus_rd;
    logic         pop_req;
    logic         stat_clr;
    logic [7:0]   fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fifo_count_next;
    logic         fifo_full, fifo_empty, fifo_drop;
    logic [7:0]   status_byte;

    assign bus_rd = ena & ~rdn;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (rx_valid),
        .pop        (pop_req),
        .wdata      (rx_data),
        .rdata      (fifo_rdata),
        .count      (fifo_count),
        .count_next (fifo_count_next),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .drop       (fifo_drop)
    );

    // Bus FSM: one commit per CPU read, taken when the read strobe goes away
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        pop_req  = 1'b0;
        stat_clr = 1'b0;
        case (state_q)
            RXB_IDLE: begin
                if (bus_rd) begin
                    state_d = RXB_RD;
                    sel_d   = addr0;
                end
            end
            RXB_RD: begin
                if (!bus_rd) begin
                    state_d = RXB_IDLE;
                    if (sel_q) begin
                        stat_clr = 1'b1;
                    end else begin
                        pop_req = ~fifo_empty;
                    end
                end
            end
            default: state_d = RXB_IDLE;
        endcase
    end

    // Sticky overrun: a drop in the same cycle as a clear keeps the flag set
    always_comb begin
        overrun_d = overrun_q;
        if (stat_clr) begin
            overrun_d = 1'b0;
        end
        if (fifo_drop) begin
            overrun_d = 1'b1;
        end
    end

    // Bus FSM, latched register select and overrun flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RXB_IDLE;
            sel_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            overrun_q <= overrun_d;
        end
    end

    // Status byte assembly
    always_comb begin
        status_byte = '0;
        status_byte[STAT_OVR] = overrun_q;
        status_byte[STAT_CNT_MSB:0] = sat_count5(32'(fifo_count));
    end

    // Read data mux onto the bus
    always_comb begin
        dslave = 8'h00;
        if (bus_rd) begin
            if (addr0) begin
                dslave = status_byte;
            end else if (!fifo_empty) begin
                dslave = fifo_rdata;
            end
        end
    end

    assign mwait = ~(bus_rd & ~addr0 & fifo_empty);
    assign full  = fifo_full;
    assign empty = fifo_empty;

`ifdef Z80_UART_RXFIFO_IRQ_EN
    logic irq_n_q, irq_n_d;

    // Interrupt follows the fill level the FIFO is about to reach
    always_comb begin
        irq_n_d = ~(fifo_count_next >= CW'(IRQ_LEVEL));
    end

    // Registered interrupt line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_n_q <= 1'b1;
        end else begin
            irq_n_q <= irq_n_d;
        end
    end

    assign irq_n = irq_n_q;
`else
    logic unused_irq;
    assign unused_irq = ^{fifo_count_next, 32'(IRQ_LEVEL)};
`endif

endmodule

// File: tb/tb_z80_uart_rx_fifo.sv
// Scoreboard bench for z80_uart_rx_fifo: received bytes are queued in a model
// when pushed and compared when the CPU reads them back.
module tb_z80_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       rdn;
    logic       addr0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] dslave;
    logic       mwait;
    logic       full;
    logic       empty;
`ifdef Z80_UART_RXFIFO_IRQ_EN
    logic       irq_n;
`endif

    int check_cnt = 0;
    int err_cnt   = 0;

    logic [7:0] exp_q[$];
    logic       model_ovr;

`ifdef Z80_UART_RXFIFO_IRQ_EN
    z80_uart_rx_fifo #(.DEPTH(DEPTH), .IRQ_LEVEL(2)) dut (
`else
    z80_uart_rx_fifo #(.DEPTH(DEPTH)) dut (
`endif
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .rdn      (rdn),
        .addr0    (addr0),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .dslave   (dslave),
        .mwait    (mwait),
        .full     (full),
        .empty    (empty)
`ifdef Z80_UART_RXFIFO_IRQ_EN
        ,
        .irq_n    (irq_n)
`endif
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the run ever wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] expStatus();
        int unsigned n;
        n = exp_q.size();
        if (n > 31) n = 31;
        return {model_ovr, 2'b00, n[4:0]};
    endfunction

    // One-cycle rx strobe; the model keeps the byte only if there is room
    task automatic applyPush(input logic [7:0] b);
        tick();
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else model_ovr = 1'b1;
    endtask

    // Data read with rdn low for 'hold' clocks, caller guarantees model non-empty
    task automatic applyDataRead(input string tag, input int hold);
        logic [7:0] exp_byte;
        tick();
        ena = 1'b1; rdn = 1'b0; addr0 = 1'b0;
        @(negedge clk);
        exp_byte = exp_q.pop_front();
        checkOutput({tag, "_mwait"}, mwait, 1'b1);
        checkOutput({tag, "_data"}, dslave, exp_byte);
        for (int i = 1; i < hold; i++) tick();
        if (hold > 1) begin
            @(negedge clk);
            checkOutput({tag, "_hold"}, dslave, exp_byte);
        end
        tick();
        rdn = 1'b1; ena = 1'b0;
        tick();
    endtask

    // Status read; its commit clears the overrun flag
    task automatic applyStatusRead(input string tag);
        tick();
        ena = 1'b1; rdn = 1'b0; addr0 = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_mwait"}, mwait, 1'b1);
        checkOutput({tag, "_status"}, dslave, expStatus());
        tick();
        rdn = 1'b1; ena = 1'b0; addr0 = 1'b0;
        model_ovr = 1'b0;
        tick();
    endtask

    initial begin
        int low_cnt;
        logic released;

        rst_n = 1'b0; ena = 1'b0; rdn = 1'b1; addr0 = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00;
        model_ovr = 1'b0;
        tick(); tick();
        @(negedge clk);
        checkOutput("rst_empty", empty, 1'b1);
        checkOutput("rst_full", full, 1'b0);
        checkOutput("rst_dslave", dslave, 8'h00);
        checkOutput("rst_mwait", mwait, 1'b1);
`ifdef Z80_UART_RXFIFO_IRQ_EN
        checkOutput("rst_irq_n", irq_n, 1'b1);
`endif
        tick();
        rst_n = 1'b1;

        // Two bytes with gaps, then two long data reads
        $display("[TB] test 1: basic push/read");
        applyPush(8'hA5);
        repeat (3) tick();
        applyPush(8'h3C);
        repeat (3) tick();
        applyStatusRead("t1_stat2");
        applyDataRead("t1_rd0", 4);
        applyDataRead("t1_rd1", 4);
        @(negedge clk);
        checkOutput("t1_empty", empty, 1'b1);
        applyStatusRead("t1_stat0");

        // Data read of empty FIFO stalls until a byte lands
        $display("[TB] test 2: stall on empty");
        tick();
        ena = 1'b1; rdn = 1'b0; addr0 = 1'b0;
        low_cnt = 0;
        released = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 6) begin
                rx_valid = 1'b1;
                rx_data  = 8'h55;
                exp_q.push_back(8'h55);
            end
            if (i == 7) rx_valid = 1'b0;
            @(negedge clk);
            if (mwait === 1'b1) begin
                released = 1'b1;
                break;
            end
            low_cnt++;
            tick();
        end
        rx_valid = 1'b0;
        checkOutput("t2_released", released, 1'b1);
        checkOutput("t2_wait_cycles", low_cnt, 7);
        checkOutput("t2_data", dslave, exp_q.pop_front());
        tick();
        rdn = 1'b1; ena = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("t2_empty", empty, 1'b1);

        // Overfill with no reads
        $display("[TB] test 3: overflow");
        for (int i = 0; i <= DEPTH; i++) applyPush(8'(i));
        @(negedge clk);
        checkOutput("t3_full", full, 1'b1);
        checkOutput("t3_model_status", expStatus(), 8'h90);
        applyStatusRead("t3_stat_ovr");
        applyStatusRead("t3_stat_clr");

        // Full FIFO: push lands on the same edge as a read commit
        $display("[TB] test 4: push with commit while full");
        tick();
        ena = 1'b1; rdn = 1'b0; addr0 = 1'b0;
        @(negedge clk);
        checkOutput("t4_head", dslave, exp_q.pop_front());
        tick();
        rdn = 1'b1; ena = 1'b0;
        rx_valid = 1'b1; rx_data = 8'hEE;
        exp_q.push_back(8'hEE);
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        checkOutput("t4_full", full, 1'b1);
        applyStatusRead("t4_stat");
        for (int i = 0; i < DEPTH; i++) begin
            if (exp_q.size() > 0) applyDataRead("t4_drain", 1);
        end
        @(negedge clk);
        checkOutput("t4_empty", empty, 1'b1);

        // Reset in the middle of a data read
        $display("[TB] test 5: reset mid-read");
        applyPush(8'h31);
        applyPush(8'h32);
        applyPush(8'h33);
        tick();
        ena = 1'b1; rdn = 1'b0; addr0 = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; rdn = 1'b1; ena = 1'b0;
        exp_q.delete();
        model_ovr = 1'b0;
        @(negedge clk);
        checkOutput("t5_empty", empty, 1'b1);
        checkOutput("t5_mwait", mwait, 1'b1);
        checkOutput("t5_dslave", dslave, 8'h00);
        applyStatusRead("t5_stat");
        applyPush(8'h77);
        applyDataRead("t5_rd", 2);
        applyStatusRead("t5_stat_after");

`ifdef Z80_UART_RXFIFO_IRQ_EN
        // Interrupt threshold at two bytes
        $display("[TB] test 6: irq level");
        applyPush(8'h01);
        @(negedge clk);
        checkOutput("t6_irq_one", irq_n, (exp_q.size() >= 2) ? 1'b0 : 1'b1);
        applyPush(8'h02);
        @(negedge clk);
        checkOutput("t6_irq_two", irq_n, (exp_q.size() >= 2) ? 1'b0 : 1'b1);
        applyDataRead("t6_rd", 1);
        @(negedge clk);
        checkOutput("t6_irq_after", irq_n, (exp_q.size() >= 2) ? 1'b0 : 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
